mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/byte_lane_unit.sv | 23 ++
 rtl/mem_port_arbiter.sv | 83 ++++++++
 tb/tb_mem_port_arbiter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared owner encoding, response record, byte-enable width and burst default for the memory port arbiter
package mem_arb_pkg;
  localparam int BE_W = 4;
  localparam int MAX_DATA_BURST_DEF = 4;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_FETCH = 2'd1, OWN_DATA = 2'd2} owner_t;
  typedef struct packed {
    owner_t     own;
    logic [1:0] lane;
    logic       byte_acc;
    logic       signext;
    logic       err;
    logic       wr;
  } resp_t;
endpackage

// File: rtl/byte_lane_unit.sv
// byte_lane_unit: store lane enables/replication (byte_acc, st_lane, st_data -> st_be, st_wdata) and load lane select/extension (ld_* -> ld_data)
module byte_lane_unit
  import mem_arb_pkg::*;
(
  input  logic            byte_acc,
  input  logic [1:0]      st_lane,
  input  logic [31:0]     st_data,
  output logic [BE_W-1:0] st_be,
  output logic [31:0]     st_wdata,
  input  logic            ld_byte,
  input  logic [1:0]      ld_lane,
  input  logic            ld_signext,
  input  logic [31:0]     ld_raw,
  output logic [31:0]     ld_data
);
  logic [7:0] ld_b;
  always_comb begin
    st_be    = byte_acc ? BE_W'(1) << st_lane : {BE_W{1'b1}};
    st_wdata = byte_acc ? {4{st_data[7:0]}} : st_data;
    ld_b     = ld_raw[{ld_lane, 3'b000} +: 8];
    ld_data  = ld_byte ? {{24{ld_signext & ld_b[7]}}, ld_b} : ld_raw;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: single memory port shared by fetch (if_*) and data (d_*) requesters; drives mem_* and returns one-cycle-later responses
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_DATA_BURST = MAX_DATA_BURST_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [31:0]     if_addr,
  output logic [31:0]     if_rdata,
  output logic            if_valid,
  output logic            if_stall,
  input  logic            d_read,
  input  logic            d_we,
  input  logic            d_byte,
  input  logic            d_signext,
  input  logic [31:0]     d_addr,
  input  logic [31:0]     d_wdata,
  output logic [31:0]     d_rdata,
  output logic            d_valid,
  output logic            d_stall,
  output logic            d_err,
  output logic            mem_en,
  output logic [BE_W-1:0] mem_be,
  output logic [29:0]     mem_addr,
  output logic [31:0]     mem_wdata,
  input  logic [31:0]     mem_rdata
);
  localparam int CW = $clog2(MAX_DATA_BURST + 1);
  logic [CW-1:0]   burst;
  resp_t           resp, resp_next;
  logic            data_req, fetch_grant, data_grant, mis, store, unused_if_lo;
  logic [BE_W-1:0] lane_be;
  logic [31:0]     lane_wdata, ld_data;
  assign unused_if_lo = ^if_addr[1:0];
  assign data_req     = d_read | d_we;
  assign fetch_grant  = rst_n & if_req & (~data_req | (burst == CW'(MAX_DATA_BURST)));
  assign data_grant   = rst_n & data_req & ~fetch_grant;
  assign mis          = ~d_byte & (|d_addr[1:0]);
  assign store        = data_grant & d_we & ~mis;
  assign if_stall     = rst_n & if_req & ~fetch_grant;
  assign d_stall      = rst_n & data_req & ~data_grant;
  assign mem_en       = fetch_grant | (data_grant & ~mis);
  assign mem_addr     = fetch_grant ? if_addr[31:2] : mem_en ? d_addr[31:2] : '0;
  assign mem_be       = store ? lane_be : '0;
  assign mem_wdata    = store ? lane_wdata : '0;
  byte_lane_unit u_lane (
    .byte_acc   (d_byte),
    .st_lane    (d_addr[1:0]),
    .st_data    (d_wdata),
    .st_be      (lane_be),
    .st_wdata   (lane_wdata),
    .ld_byte    (resp.byte_acc),
    .ld_lane    (resp.lane),
    .ld_signext (resp.signext),
    .ld_raw     (mem_rdata),
    .ld_data    (ld_data)
  );
  always_comb begin
    resp_next          = '0;
    resp_next.own      = fetch_grant ? OWN_FETCH : data_grant ? OWN_DATA : OWN_NONE;
    resp_next.lane     = d_addr[1:0];
    resp_next.byte_acc = d_byte;
    resp_next.signext  = d_signext;
    resp_next.err      = mis;
    resp_next.wr       = d_we;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst <= '0;
      resp  <= '0;
    end else begin
      burst <= (!if_req || fetch_grant) ? '0 : (data_grant && burst != CW'(MAX_DATA_BURST)) ? burst + CW'(1) : burst;
      resp  <= resp_next;
    end
  end
  assign if_valid = rst_n & (resp.own == OWN_FETCH);
  assign d_valid  = rst_n & (resp.own == OWN_DATA);
  assign if_rdata = if_valid ? mem_rdata : '0;
  assign d_err    = d_valid & resp.err;
  assign d_rdata  = (d_valid & ~resp.err & ~resp.wr) ? ld_data : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  logic        clk = 0, rst_n = 0;
  logic        if_req = 0, d_read = 0, d_we = 0, d_byte = 0, d_signext = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
  logic [31:0] if_rdata, d_rdata, mem_wdata;
  logic        if_valid, if_stall, d_valid, d_stall, d_err, mem_en;
  logic [3:0]  mem_be;
  logic [29:0] mem_addr;
  int          total = 0, bad = 0;
  logic        exp_f, prev_f;
  always #5 clk = ~clk;
  mem_port_arbiter #(.MAX_DATA_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .d_read(d_read), .d_we(d_we), .d_byte(d_byte), .d_signext(d_signext), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall), .d_err(d_err),
    .mem_en(mem_en), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    if_req = 0; d_read = 0; d_we = 0; d_byte = 0; d_signext = 0;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_flags"}, {22'd0, if_valid, if_stall, d_valid, d_stall, d_err, mem_en, mem_be}, 32'd0);
    chk({tag, "_maddr"}, {2'd0, mem_addr}, 32'd0);
    chk({tag, "_mwdata"}, mem_wdata, 32'd0);
    chk({tag, "_ifrdata"}, if_rdata, 32'd0);
    chk({tag, "_drdata"}, d_rdata, 32'd0);
  endtask
  initial begin
    if_req = 1; d_read = 1; d_we = 1; d_addr = 32'h104; d_wdata = 32'h55; mem_rdata = 32'hDEADBEEF;
    #1 chk_zero("rst_async");
    tick();
    tick();
    chk_zero("rst_held");
    idle();
    rst_n = 1;
    #1;
    if_req = 1; if_addr = 32'h40; mem_rdata = 32'h11111111;
    #1;
    chk("if1_en", {31'd0, mem_en}, 32'd1);
    chk("if1_addr", {2'd0, mem_addr}, 32'h10);
    chk("if1_stall", {31'd0, if_stall}, 32'd0);
    chk("if1_valid", {31'd0, if_valid}, 32'd0);
    chk("if1_be", {28'd0, mem_be}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("ifn_addr", {2'd0, mem_addr}, 32'h10);
      chk("ifn_stall", {31'd0, if_stall}, 32'd0);
      chk("ifn_valid", {31'd0, if_valid}, 32'd1);
      chk("ifn_rdata", if_rdata, 32'h11111111);
    end
    tick();
    idle();
    #1;
    chk("if4_valid", {31'd0, if_valid}, 32'd1);
    chk("if4_en", {31'd0, mem_en}, 32'd0);
    tick();
    chk("if5_valid", {31'd0, if_valid}, 32'd0);
    chk("if5_rdata", if_rdata, 32'd0);
    if_req = 1; if_addr = 32'h40; d_read = 1; d_addr = 32'h100; mem_rdata = 32'h0;
    prev_f = 0;
    for (int i = 0; i < 10; i++) begin
      exp_f = (i % 5 == 4);
      #1;
      chk("bur_dstall", {31'd0, d_stall}, {31'd0, exp_f});
      chk("bur_ifstall", {31'd0, if_stall}, {31'd0, ~exp_f});
      chk("bur_addr", {2'd0, mem_addr}, exp_f ? 32'h10 : 32'h40);
      chk("bur_en", {31'd0, mem_en}, 32'd1);
      if (i > 0) begin
        chk("bur_ifvalid", {31'd0, if_valid}, {31'd0, prev_f});
        chk("bur_dvalid", {31'd0, d_valid}, {31'd0, ~prev_f});
      end
      prev_f = exp_f;
      tick();
    end
    idle();
    #1;
    chk("bur_last_ifvalid", {31'd0, if_valid}, 32'd1);
    chk("bur_last_dvalid", {31'd0, d_valid}, 32'd0);
    tick();
    d_we = 1; d_byte = 1; d_addr = 32'h203; d_wdata = 32'h000000AB;
    #1;
    chk("sb_be", {28'd0, mem_be}, 32'h8);
    chk("sb_wdata", mem_wdata, 32'hABABABAB);
    chk("sb_addr", {2'd0, mem_addr}, 32'h80);
    chk("sb_en", {31'd0, mem_en}, 32'd1);
    tick();
    idle();
    d_read = 1; d_we = 1; d_addr = 32'h204; d_wdata = 32'h12345678; mem_rdata = 32'hCAFEF00D;
    #1;
    chk("sb_dvalid", {31'd0, d_valid}, 32'd1);
    chk("sb_drdata", d_rdata, 32'd0);
    chk("sb_derr", {31'd0, d_err}, 32'd0);
    chk("sw_be", {28'd0, mem_be}, 32'hF);
    chk("sw_wdata", mem_wdata, 32'h12345678);
    chk("sw_addr", {2'd0, mem_addr}, 32'h81);
    tick();
    idle();
    d_read = 1; d_byte = 1; d_signext = 1; d_addr = 32'h201;
    #1;
    chk("sw_dvalid", {31'd0, d_valid}, 32'd1);
    chk("sw_drdata", d_rdata, 32'd0);
    chk("lb1_be", {28'd0, mem_be}, 32'd0);
    chk("lb1_addr", {2'd0, mem_addr}, 32'h80);
    tick();
    d_signext = 0; mem_rdata = 32'h0000F000;
    #1;
    chk("lb1_dvalid", {31'd0, d_valid}, 32'd1);
    chk("lb1_sext", d_rdata, 32'hFFFFFFF0);
    chk("lb2_en", {31'd0, mem_en}, 32'd1);
    tick();
    d_addr = 32'h103;
    #1;
    chk("lb2_zext", d_rdata, 32'h000000F0);
    tick();
    d_byte = 0; d_addr = 32'h100; mem_rdata = 32'h8F000000;
    #1;
    chk("lb3_lane3", d_rdata, 32'h0000008F);
    tick();
    idle();
    d_read = 1; d_addr = 32'h102; mem_rdata = 32'hCAFEBABE;
    #1;
    chk("lw_data", d_rdata, 32'hCAFEBABE);
    chk("mis_en", {31'd0, mem_en}, 32'd0);
    chk("mis_stall", {31'd0, d_stall}, 32'd0);
    tick();
    idle();
    mem_rdata = 32'hFFFFFFFF;
    #1;
    chk("mis_err", {31'd0, d_err}, 32'd1);
    chk("mis_valid", {31'd0, d_valid}, 32'd1);
    chk("mis_rdata", d_rdata, 32'd0);
    tick();
    chk("mis_after", {31'd0, d_err}, 32'd0);
    if_req = 1; if_addr = 32'h80;
    #1;
    chk("rf_en", {31'd0, mem_en}, 32'd1);
    chk("rf_addr", {2'd0, mem_addr}, 32'h20);
    #2 rst_n = 0;
    #1 chk_zero("rf_rst");
    tick();
    chk_zero("rf_rst_edge");
    idle();
    rst_n = 1;
    #1;
    chk("rf_post_ifvalid", {31'd0, if_valid}, 32'd0);
    tick();
    chk("rf_post2_ifvalid", {31'd0, if_valid}, 32'd0);
    if_req = 1; if_addr = 32'h44;
    #1;
    chk("rf_new_en", {31'd0, mem_en}, 32'd1);
    chk("rf_new_addr", {2'd0, mem_addr}, 32'h11);
    tick();
    idle();
    #1;
    chk("rf_new_valid", {31'd0, if_valid}, 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
